// File: rtl/clock_divider_bank_pkg.sv
// Shared definitions for the clock divider bank: smallest legal ratio,
// the per-channel run states and the ratio legality check.
package clock_divider_bank_pkg;

  localparam int unsigned DIV_MIN = 32'd2;

  typedef enum logic [0:0] {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } run_state_t;

  function automatic logic ratio_legal(input logic [31:0] ratio);
    return (ratio >= DIV_MIN);
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One integer clock divider: run/stop FSM, period counter, active and pending
// ratios, registered complementary outputs, edge strobes and sticky ratio error.
module clkdiv_channel
  import clock_divider_bank_pkg::*;
#(
  parameter int unsigned      DIV_W   = 8,
  parameter logic [DIV_W-1:0] RST_DIV = DIV_W'(2),
  parameter logic             RST_EN  = 1'b1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             ch_en,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_in,
  input  logic             sync_restart,
  output logic             clk_out,
  output logic             clk_out_n,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic             running,
  output logic             div_err
);

  localparam logic [DIV_W-1:0] ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] ONE  = DIV_W'(1);

  run_state_t       state_r;
  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] div_act_r;
  logic [DIV_W-1:0] div_pend_r;
  logic             boot_r;
  logic             clk_r;
  logic             clk_n_r;
  logic             rise_r;
  logic             fall_r;
  logic             err_r;

  logic             load_ok_s;
  logic [DIV_W-1:0] pend_next_s;
  logic [DIV_W-1:0] cnt_inc_s;
  logic [DIV_W:0]   high_len_s;
  logic             hi_next_s;
  logic             last_s;
  logic             start_s;

  // Pending-ratio bypass and phase decode of the running counter
  always_comb begin
    load_ok_s = div_load & ratio_legal(32'(div_in));
    if (load_ok_s) begin
      pend_next_s = div_in;
    end else begin
      pend_next_s = div_pend_r;
    end
    cnt_inc_s  = cnt_r + ONE;
    // One bit wider so that the high length of ratio 2^DIV_W-1 does not wrap
    high_len_s = ({1'b0, div_act_r} + {1'b0, ONE}) >> 1'b1;
    hi_next_s  = ({1'b0, cnt_inc_s} < high_len_s);
    last_s     = (cnt_r == (div_act_r - ONE));
    start_s    = ch_en | boot_r;
  end

  // Pending ratio and sticky illegal-load flag
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_pend_r <= RST_DIV;
      err_r      <= 1'b0;
    end else begin
      div_pend_r <= pend_next_s;
      if (div_load) begin
        err_r <= ~load_ok_s;
      end
    end
  end

  // Run/stop FSM: counter, active ratio, divided clock and one-cycle strobes
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r   <= ST_STOP;
      boot_r    <= RST_EN;
      cnt_r     <= ZERO;
      div_act_r <= RST_DIV;
      clk_r     <= 1'b0;
      clk_n_r   <= 1'b1;
      rise_r    <= 1'b0;
      fall_r    <= 1'b0;
    end else begin
      boot_r <= 1'b0;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      case (state_r)
        ST_STOP: begin
          if (start_s) begin
            state_r   <= ST_RUN;
            cnt_r     <= ZERO;
            div_act_r <= pend_next_s;
            clk_r     <= 1'b1;
            clk_n_r   <= 1'b0;
            rise_r    <= 1'b1;
          end else begin
            clk_r   <= 1'b0;
            clk_n_r <= 1'b1;
          end
        end
        ST_RUN: begin
          if (sync_restart) begin
            // Truncate the period; a rise is only reported if the output was low
            cnt_r     <= ZERO;
            div_act_r <= pend_next_s;
            clk_r     <= 1'b1;
            clk_n_r   <= 1'b0;
            rise_r    <= ~clk_r;
          end else if (last_s) begin
            if (ch_en) begin
              cnt_r     <= ZERO;
              div_act_r <= pend_next_s;
              clk_r     <= 1'b1;
              clk_n_r   <= 1'b0;
              rise_r    <= 1'b1;
            end else begin
              state_r <= ST_STOP;
              cnt_r   <= ZERO;
              clk_r   <= 1'b0;
              clk_n_r <= 1'b1;
            end
          end else begin
            cnt_r   <= cnt_inc_s;
            clk_r   <= hi_next_s;
            clk_n_r <= ~hi_next_s;
            fall_r  <= clk_r & ~hi_next_s;
          end
        end
        default: begin
          state_r <= ST_STOP;
          cnt_r   <= ZERO;
          clk_r   <= 1'b0;
          clk_n_r <= 1'b1;
        end
      endcase
    end
  end

  assign clk_out   = clk_r;
  assign clk_out_n = clk_n_r;
  assign rise_stb  = rise_r;
  assign fall_stb  = fall_r;
  assign running   = (state_r == ST_RUN);
  assign div_err   = err_r;

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of NUM_CH independent programmable clock dividers on one input clock;
// the top only slices the packed ratio vectors and fans out sync_restart.
module clock_divider_bank
  import clock_divider_bank_pkg::*;
#(
  parameter int unsigned               NUM_CH  = 4,
  parameter int unsigned               DIV_W   = 8,
  parameter logic [NUM_CH*DIV_W-1:0]   RST_DIV = {4{8'd2}},
  parameter logic [NUM_CH-1:0]         RST_EN  = {NUM_CH{1'b1}}
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH-1:0]       div_load,
  input  logic [NUM_CH*DIV_W-1:0] div_in,
  input  logic                    sync_restart,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       clk_out_n,
  output logic [NUM_CH-1:0]       rise_stb,
  output logic [NUM_CH-1:0]       fall_stb,
  output logic [NUM_CH-1:0]       running,
  output logic [NUM_CH-1:0]       div_err
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clkdiv_channel #(
      .DIV_W   (DIV_W),
      .RST_DIV (RST_DIV[i*DIV_W +: DIV_W]),
      .RST_EN  (RST_EN[i])
    ) u_ch (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .ch_en        (ch_en[i]),
      .div_load     (div_load[i]),
      .div_in       (div_in[i*DIV_W +: DIV_W]),
      .sync_restart (sync_restart),
      .clk_out      (clk_out[i]),
      .clk_out_n    (clk_out_n[i]),
      .rise_stb     (rise_stb[i]),
      .fall_stb     (fall_stb[i]),
      .running      (running[i]),
      .div_err      (div_err[i])
    );
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Scoreboard bench for clock_divider_bank: a per-channel phase model predicts
// every output each cycle; directed scenarios cover start, stop, loads, restart, reset.
module tb_clock_divider_bank;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;
  localparam int VW     = 6 * NUM_CH;

  logic                    sys_clk = 1'b0;
  logic                    sys_rst_n;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH-1:0]       div_load;
  logic [NUM_CH*DIV_W-1:0] div_in;
  logic                    sync_restart;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       clk_out_n;
  logic [NUM_CH-1:0]       rise_stb;
  logic [NUM_CH-1:0]       fall_stb;
  logic [NUM_CH-1:0]       running;
  logic [NUM_CH-1:0]       div_err;

  always #5 sys_clk = ~sys_clk;

  clock_divider_bank #(
    .NUM_CH  (NUM_CH),
    .DIV_W   (DIV_W),
    .RST_DIV ({4{8'd2}}),
    .RST_EN  (4'hF)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .ch_en        (ch_en),
    .div_load     (div_load),
    .div_in       (div_in),
    .sync_restart (sync_restart),
    .clk_out      (clk_out),
    .clk_out_n    (clk_out_n),
    .rise_stb     (rise_stb),
    .fall_stb     (fall_stb),
    .running      (running),
    .div_err      (div_err)
  );

  int n_vec = 0;
  int n_err = 0;
  string cur = "rst";
  logic [VW-1:0] exp_q[$];

  // Reference model state, one entry per channel
  int m_pos [NUM_CH];
  int m_d   [NUM_CH];
  int m_pend[NUM_CH];
  bit m_run [NUM_CH];
  bit m_clk [NUM_CH];
  bit m_err [NUM_CH];
  bit m_boot[NUM_CH];
  bit m_rise[NUM_CH];
  bit m_fall[NUM_CH];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_pos[i]  = 0;
      m_d[i]    = 2;
      m_pend[i] = 2;
      m_run[i]  = 1'b0;
      m_clk[i]  = 1'b0;
      m_err[i]  = 1'b0;
      m_boot[i] = 1'b1;
      m_rise[i] = 1'b0;
      m_fall[i] = 1'b0;
    end
  endtask

  // Advance the model by one edge using the inputs currently driven
  task automatic model_step();
    for (int i = 0; i < NUM_CH; i++) begin
      int din;
      int pn;
      din = int'(div_in[i*DIV_W +: DIV_W]);
      pn  = (div_load[i] && din >= 2) ? din : m_pend[i];
      m_rise[i] = 1'b0;
      m_fall[i] = 1'b0;
      if (!m_run[i]) begin
        if (ch_en[i] || m_boot[i]) begin
          m_run[i] = 1'b1; m_pos[i] = 0; m_d[i] = pn; m_clk[i] = 1'b1; m_rise[i] = 1'b1;
        end
      end else if (sync_restart) begin
        m_rise[i] = !m_clk[i]; m_pos[i] = 0; m_d[i] = pn; m_clk[i] = 1'b1;
      end else if (m_pos[i] == m_d[i] - 1) begin
        if (ch_en[i]) begin
          m_pos[i] = 0; m_d[i] = pn; m_clk[i] = 1'b1; m_rise[i] = 1'b1;
        end else begin
          m_run[i] = 1'b0; m_pos[i] = 0; m_clk[i] = 1'b0;
        end
      end else begin
        m_pos[i]++;
        m_fall[i] = m_clk[i] && !(2 * m_pos[i] < m_d[i]);
        m_clk[i]  = (2 * m_pos[i] < m_d[i]);
      end
      if (div_load[i]) m_err[i] = (din < 2);
      m_pend[i] = pn;
      m_boot[i] = 1'b0;
    end
  endtask

  function automatic logic [VW-1:0] model_vec();
    logic [NUM_CH-1:0] c, r, f, ru, e;
    for (int i = 0; i < NUM_CH; i++) begin
      c[i] = m_clk[i]; r[i] = m_rise[i]; f[i] = m_fall[i]; ru[i] = m_run[i]; e[i] = m_err[i];
    end
    return {c, ~c, r, f, ru, e};
  endfunction

  // One clock: predict, let the DUT step, compare, release strobes
  task automatic cycle();
    logic [VW-1:0] e;
    model_step();
    exp_q.push_back(model_vec());
    @(posedge sys_clk);
    #1;
    e = exp_q.pop_front();
    check_val({cur, ".clk_out"},   32'(clk_out),   32'(e[6*NUM_CH-1 -: NUM_CH]));
    check_val({cur, ".clk_out_n"}, 32'(clk_out_n), 32'(e[5*NUM_CH-1 -: NUM_CH]));
    check_val({cur, ".rise_stb"},  32'(rise_stb),  32'(e[4*NUM_CH-1 -: NUM_CH]));
    check_val({cur, ".fall_stb"},  32'(fall_stb),  32'(e[3*NUM_CH-1 -: NUM_CH]));
    check_val({cur, ".running"},   32'(running),   32'(e[2*NUM_CH-1 -: NUM_CH]));
    check_val({cur, ".div_err"},   32'(div_err),   32'(e[NUM_CH-1 -: NUM_CH]));
    div_load     = {NUM_CH{1'b0}};
    sync_restart = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic bound_ok(input string tag, input int k, input int lim);
    check_val({tag, ".wait_bound"}, 32'(k < lim), 32'd1);
  endtask

  initial begin
    int k, nr, nf, nh;
    sys_rst_n    = 1'b0;
    ch_en        = 4'hF;
    div_load     = 4'h0;
    div_in       = 32'h0;
    sync_restart = 1'b0;
    model_reset();
    #12;
    check_val("rst.clk_out",   32'(clk_out),   32'h0);
    check_val("rst.clk_out_n", 32'(clk_out_n), 32'hF);
    check_val("rst.rise_stb",  32'(rise_stb),  32'h0);
    check_val("rst.fall_stb",  32'(fall_stb),  32'h0);
    check_val("rst.running",   32'(running),   32'h0);
    check_val("rst.div_err",   32'(div_err),   32'h0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // T1: default ratio 2, all channels start on the first edge
    cur = "t1";
    cycle();
    check_val("t1.first_rise", 32'(rise_stb), 32'hF);
    repeat (6) cycle();

    // T2: load ratio 5 into ch0 mid-period
    cur = "t2";
    k = 0;
    while (m_pos[0] != 0 && k < 10) begin cycle(); k++; end
    bound_ok("t2a", k, 10);
    div_in[7:0] = 8'd5; div_load = 4'b0001;
    cycle();
    k = 0;
    while (!(m_d[0] == 5 && m_pos[0] == 0) && k < 20) begin cycle(); k++; end
    bound_ok("t2b", k, 20);
    nr = 0; nf = 0; nh = 0;
    for (int c = 0; c < 10; c++) begin
      cycle();
      nr += int'(rise_stb[0]); nf += int'(fall_stb[0]); nh += int'(clk_out[0]);
    end
    check_val("t2.rise_count", 32'(nr), 32'd2);
    check_val("t2.fall_count", 32'(nf), 32'd2);
    check_val("t2.high_count", 32'(nh), 32'd6);

    // T3: ch1 ratio 6, drop enable at cnt 1, period completes, then restart
    cur = "t3";
    div_in[15:8] = 8'd6; div_load = 4'b0010;
    cycle();
    k = 0;
    while (!(m_d[1] == 6 && m_pos[1] == 1) && k < 20) begin cycle(); k++; end
    bound_ok("t3a", k, 20);
    ch_en[1] = 1'b0;
    repeat (5) cycle();
    check_val("t3.stopped", 32'(running[1]), 32'd0);
    repeat (3) cycle();
    check_val("t3.held_low", 32'(clk_out[1]), 32'd0);
    ch_en[1] = 1'b1;
    cycle();
    check_val("t3.restart_high", 32'(clk_out[1]), 32'd1);
    check_val("t3.restart_rise", 32'(rise_stb[1]), 32'd1);
    repeat (6) cycle();

    // T4: illegal ratio 1 on ch2, then legal ratio 4
    cur = "t4";
    div_in[23:16] = 8'd1; div_load = 4'b0100;
    cycle();
    check_val("t4.err_set", 32'(div_err[2]), 32'd1);
    repeat (4) cycle();
    div_in[23:16] = 8'd4; div_load = 4'b0100;
    cycle();
    check_val("t4.err_clr", 32'(div_err[2]), 32'd0);
    k = 0;
    while (m_d[2] != 4 && k < 10) begin cycle(); k++; end
    bound_ok("t4", k, 10);
    repeat (8) cycle();

    // T5: ch0 ratio 3, ch1 ratio 7, ch2 stopped, then sync_restart
    cur = "t5";
    ch_en[2] = 1'b0;
    k = 0;
    while (m_run[2] && k < 10) begin cycle(); k++; end
    bound_ok("t5a", k, 10);
    div_in[15:0] = {8'd7, 8'd3}; div_load = 4'b0011;
    cycle();
    k = 0;
    while (!(m_d[0] == 3 && m_d[1] == 7 && !m_clk[0]) && k < 30) begin cycle(); k++; end
    bound_ok("t5b", k, 30);
    sync_restart = 1'b1;
    cycle();
    check_val("t5.both_high", 32'(clk_out[1:0]), 32'd3);
    check_val("t5.ch2_low",   32'(clk_out[2]),   32'd0);
    check_val("t5.ch0_rise",  32'(rise_stb[0]),  32'd1);
    k = 0;
    while (m_pos[0] != 2 && k < 10) begin cycle(); k++; end
    bound_ok("t5c", k, 10);
    sync_restart = 1'b1;
    cycle();
    check_val("t5.bnd_rise", 32'(rise_stb[0]), 32'd1);
    cycle();
    check_val("t5.single_rise", 32'(rise_stb[0]), 32'd0);
    repeat (10) cycle();

    // T6: asynchronous reset in a high phase, ratios return to default
    cur = "t6";
    div_in[31:24] = 8'd0; div_load = 4'b1000;
    cycle();
    k = 0;
    while (!(m_clk[0] && m_pos[0] == 0) && k < 10) begin cycle(); k++; end
    bound_ok("t6", k, 10);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check_val("t6.async_low",  32'(clk_out),   32'h0);
    check_val("t6.async_n",    32'(clk_out_n), 32'hF);
    check_val("t6.async_run",  32'(running),   32'h0);
    check_val("t6.async_err",  32'(div_err),   32'h0);
    model_reset();
    @(posedge sys_clk);
    #1;
    check_val("t6.held_low", 32'(clk_out), 32'h0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (10) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
    $fatal(1);
  end

endmodule
